axi_wr_resp_engine: RTL and testbench



---
 rtl/axi_wr_resp_engine.sv | 192 +++++++++++++++++++
 tb/tb_axi_wr_resp_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_resp_engine.sv
// AXI write slave: AW FIFO, per-beat address generation, B response, single-beat memory port.
// Optional `AXI_WR_BOUNDARY_CHK_EN: INCR bursts crossing a 4 KB boundary get SLVERR with writes suppressed.
module axi_wr_resp_engine #(
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   axi_awid,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awlock,
    input  logic [3:0]            axi_awcache,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [STRB_WIDTH-1:0] axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [ID_WIDTH-1:0]   axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [STRB_WIDTH-1:0] wr_strb
);
    localparam int         PTR_W    = $clog2(OUTSTANDING);
    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;
    state_t state_q, state_d;

    logic unused_ok;
    assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot};

    logic [ID_WIDTH-1:0]   f_id    [OUTSTANDING];
    logic [ADDR_WIDTH-1:0] f_addr  [OUTSTANDING];
    logic [7:0]            f_len   [OUTSTANDING];
    logic [2:0]            f_size  [OUTSTANDING];
    logic [1:0]            f_burst [OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, count_nxt;
    logic                  full_q, push, pop;

    logic [ID_WIDTH-1:0]   a_id;
    logic [ADDR_WIDTH-1:0] a_addr, addr_nxt, step, wrap_mask, incr_addr;
    logic [7:0]            a_len, beat_cnt;
    logic [2:0]            a_size;
    logic [1:0]            a_burst;
    logic                  err_q, w_hs, h_illegal, h_cross;

    // Full is registered, so a pop only frees a slot for the following cycle.
    assign axi_awready = rst_n && !full_q;
    assign push        = axi_awvalid && axi_awready;
    assign pop         = (state_q == IDLE) && (count != '0);
    assign count_nxt   = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_nxt;
            full_q <= (count_nxt == (PTR_W+1)'(OUTSTANDING));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_id[wr_ptr]    <= axi_awid;
            f_addr[wr_ptr]  <= axi_awaddr;
            f_len[wr_ptr]   <= axi_awlen;
            f_size[wr_ptr]  <= axi_awsize;
            f_burst[wr_ptr] <= axi_awburst;
        end
    end

    always_comb begin
        h_illegal = (f_burst[rd_ptr] == 2'b11) || (f_size[rd_ptr] > SIZE_MAX) ||
                    ((f_burst[rd_ptr] == 2'b10) &&
                     !(f_len[rd_ptr] inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

`ifdef AXI_WR_BOUNDARY_CHK_EN
    localparam int BW         = ADDR_WIDTH + 13;
    localparam bit CHK_ACTIVE = (ADDR_WIDTH > 12);
    logic [BW-1:0] b_start, b_last;
    always_comb begin
        b_start = BW'(f_addr[rd_ptr]);
        b_last  = b_start + ((BW'(f_len[rd_ptr]) + BW'(1)) << f_size[rd_ptr]) - BW'(1);
        h_cross = CHK_ACTIVE && (f_burst[rd_ptr] == 2'b01) && ((b_start >> 12) != (b_last >> 12));
    end
`else
    assign h_cross = 1'b0;
`endif

    // WRAP keeps the upper bits of the aligned (len+1)<<size block and wraps the low bits.
    always_comb begin
        step      = ADDR_WIDTH'(1) << a_size;
        wrap_mask = ((ADDR_WIDTH'(a_len) + ADDR_WIDTH'(1)) << a_size) - ADDR_WIDTH'(1);
        incr_addr = a_addr + step;
        case (a_burst)
            2'b00:   addr_nxt = a_addr;
            2'b10:   addr_nxt = (a_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: addr_nxt = incr_addr;
        endcase
    end

    assign w_hs = axi_wvalid && axi_wready;

    always_comb begin
        state_d    = state_q;
        axi_wready = 1'b0;
        axi_bvalid = 1'b0;
        case (state_q)
            IDLE:  if (count != '0) state_d = DATA;
            DATA: begin
                axi_wready = 1'b1;
                if (w_hs) begin
                    if (beat_cnt == a_len) state_d = axi_wlast ? RESP : DRAIN;
                    else if (axi_wlast)    state_d = RESP;
                end
            end
            DRAIN: begin
                axi_wready = 1'b1;
                if (w_hs && axi_wlast) state_d = RESP;
            end
            RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign axi_bid   = (state_q == RESP) ? a_id : '0;
    assign axi_bresp = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_id     <= '0;
            a_addr   <= '0;
            a_len    <= '0;
            a_size   <= '0;
            a_burst  <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= 1'b0;
            if (pop) begin
                a_id     <= f_id[rd_ptr];
                a_addr   <= f_addr[rd_ptr];
                a_len    <= f_len[rd_ptr];
                a_size   <= f_size[rd_ptr];
                a_burst  <= f_burst[rd_ptr];
                beat_cnt <= '0;
                err_q    <= h_illegal || h_cross;
            end
            // The write decision uses the error state from before this beat.
            if ((state_q == DATA) && w_hs) begin
                if (!err_q) begin
                    wr_en   <= 1'b1;
                    wr_addr <= a_addr;
                    wr_data <= axi_wdata;
                    wr_strb <= axi_wstrb;
                end
                a_addr   <= addr_nxt;
                beat_cnt <= beat_cnt + 8'd1;
                if (axi_wlast != (beat_cnt == a_len)) err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_wr_resp_engine.sv
// Directed bench for axi_wr_resp_engine: burst addressing, error responses, back-pressure and reset.
module tb_axi_wr_resp_engine;
    localparam int ID_W  = 8;
    localparam int AW    = 16;
    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam int OBS_W = AW + SW + DW;

    logic            clk, rst_n;
    logic [ID_W-1:0] axi_awid;
    logic [AW-1:0]   axi_awaddr;
    logic [7:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic [1:0]      axi_awburst;
    logic            axi_awlock;
    logic [3:0]      axi_awcache;
    logic [2:0]      axi_awprot;
    logic            axi_awvalid, axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [SW-1:0]   axi_wstrb;
    logic            axi_wlast, axi_wvalid, axi_wready;
    logic [ID_W-1:0] axi_bid;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid, axi_bready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [SW-1:0]   wr_strb;

    axi_wr_resp_engine dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] obs_q[$];
    int n_pass  = 0;
    int n_total = 0;

    always @(negedge clk) if (wr_en === 1'b1) obs_q.push_back({wr_addr, wr_strb, wr_data});

    task automatic check(input string tag, input logic [OBS_W-1:0] obs, input logic [OBS_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic exp_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int beat);
        exp_q.push_back({addr, SW'(8'hFF ^ 8'(beat)), data});
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_count"}, OBS_W'(obs_q.size()), OBS_W'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Driver tasks: each starts and ends on a falling edge.
    task automatic send_aw(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr;
        axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        for (int k = 0; k < 100; k++) begin
            if (axi_awready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); @(negedge clk); end
        axi_awvalid = 1'b0;
        check("aw_accept", OBS_W'(ok), OBS_W'(1));
    endtask

    task automatic send_beats(input int n, input int last_at, input logic [DW-1:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 0;
            axi_wvalid = 1'b1; axi_wdata = base + DW'(i);
            axi_wstrb = 8'hFF ^ 8'(i); axi_wlast = (i == last_at);
            for (int k = 0; k < 50; k++) begin
                if (axi_wready) begin ok = 1; break; end
                @(negedge clk);
            end
            if (ok) begin @(posedge clk); @(negedge clk); end
            check("w_accept", OBS_W'(ok), OBS_W'(1));
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
    endtask

    task automatic wait_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        bit ok = 0;
        axi_bready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (axi_bvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        check("b_seen", OBS_W'(ok), OBS_W'(1));
        if (ok) begin
            check("bid", OBS_W'(axi_bid), OBS_W'(id));
            check("bresp", OBS_W'(axi_bresp), OBS_W'(resp));
            @(posedge clk); @(negedge clk);
        end
        axi_bready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
        axi_awlock = 1'b0; axi_awcache = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", OBS_W'(axi_awready), OBS_W'(0));
        check("rst_bvalid", OBS_W'(axi_bvalid), OBS_W'(0));
        check("rst_wr_en", OBS_W'(wr_en), OBS_W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_awready", OBS_W'(axi_awready), OBS_W'(1));
        check("post_rst_wready", OBS_W'(axi_wready), OBS_W'(0));
        check("post_rst_bid", OBS_W'(axi_bid), OBS_W'(0));
        check("post_rst_bresp", OBS_W'(axi_bresp), OBS_W'(0));

        // W before any AW is not accepted
        axi_wvalid = 1'b1; axi_wlast = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("early_w_wready", OBS_W'(axi_wready), OBS_W'(0));
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;

        // INCR
        send_aw(8'h5A, 16'h0100, 8'd3, 3'd3, 2'b01);
        send_beats(4, 3, 64'hA000);
        wait_b(8'h5A, 2'b00);
        exp_wr(16'h0100, 64'hA000, 0); exp_wr(16'h0108, 64'hA001, 1);
        exp_wr(16'h0110, 64'hA002, 2); exp_wr(16'h0118, 64'hA003, 3);
        check_writes("incr");

        // WRAP
        send_aw(8'h33, 16'h0118, 8'd3, 3'd3, 2'b10);
        send_beats(4, 3, 64'hB000);
        wait_b(8'h33, 2'b00);
        exp_wr(16'h0118, 64'hB000, 0); exp_wr(16'h0100, 64'hB001, 1);
        exp_wr(16'h0108, 64'hB002, 2); exp_wr(16'h0110, 64'hB003, 3);
        check_writes("wrap");

        // FIXED
        send_aw(8'h44, 16'h0040, 8'd2, 3'd2, 2'b00);
        send_beats(3, 2, 64'hC000);
        wait_b(8'h44, 2'b00);
        exp_wr(16'h0040, 64'hC000, 0); exp_wr(16'h0040, 64'hC001, 1); exp_wr(16'h0040, 64'hC002, 2);
        check_writes("fixed");

        // Early wlast, then a clean burst
        send_aw(8'h01, 16'h0200, 8'd3, 3'd3, 2'b01);
        send_beats(2, 1, 64'hD000);
        wait_b(8'h01, 2'b10);
        exp_wr(16'h0200, 64'hD000, 0); exp_wr(16'h0208, 64'hD001, 1);
        check_writes("early_last");
        send_aw(8'h02, 16'h0280, 8'd0, 3'd2, 2'b01);
        send_beats(1, 0, 64'hD100);
        wait_b(8'h02, 2'b00);
        exp_wr(16'h0280, 64'hD100, 0);
        check_writes("after_early");

        // Missing wlast: two written, two drained
        send_aw(8'h03, 16'h0300, 8'd1, 3'd3, 2'b01);
        send_beats(4, 3, 64'hE000);
        wait_b(8'h03, 2'b10);
        exp_wr(16'h0300, 64'hE000, 0); exp_wr(16'h0308, 64'hE001, 1);
        check_writes("drain");

        // Illegal bursts: reserved type, oversize, bad WRAP length
        send_aw(8'h04, 16'h0000, 8'd0, 3'd3, 2'b11);
        send_beats(1, 0, 64'hF000);
        wait_b(8'h04, 2'b10);
        send_aw(8'h05, 16'h0000, 8'd0, 3'd4, 2'b01);
        send_beats(1, 0, 64'hF100);
        wait_b(8'h05, 2'b10);
        send_aw(8'h06, 16'h0000, 8'd2, 3'd3, 2'b10);
        send_beats(3, 2, 64'hF200);
        wait_b(8'h06, 2'b10);
        check_writes("illegal");

        // Back-pressure: engine parked in RESP while the FIFO fills
        send_aw(8'h11, 16'h0400, 8'd0, 3'd3, 2'b01);
        send_beats(1, 0, 64'h1100);
        exp_wr(16'h0400, 64'h1100, 0);
        send_aw(8'h21, 16'h0410, 8'd0, 3'd3, 2'b01);
        send_aw(8'h22, 16'h0420, 8'd0, 3'd3, 2'b01);
        send_aw(8'h23, 16'h0430, 8'd0, 3'd3, 2'b11);
        send_aw(8'h24, 16'h0440, 8'd0, 3'd3, 2'b01);
        check("full_awready", OBS_W'(axi_awready), OBS_W'(0));
        axi_awvalid = 1'b1; axi_awid = 8'h25; axi_awaddr = 16'h0450;
        axi_awlen = 8'd0; axi_awsize = 3'd3; axi_awburst = 2'b01;
        repeat (10) begin
            @(negedge clk);
            check("bp_bvalid", OBS_W'(axi_bvalid), OBS_W'(1));
            check("bp_bid", OBS_W'(axi_bid), OBS_W'(8'h11));
            check("bp_bresp", OBS_W'(axi_bresp), OBS_W'(0));
            check("bp_wready", OBS_W'(axi_wready), OBS_W'(0));
            check("bp_awready", OBS_W'(axi_awready), OBS_W'(0));
        end
        wait_b(8'h11, 2'b00);
        send_aw(8'h25, 16'h0450, 8'd0, 3'd3, 2'b01);
        for (int i = 1; i <= 5; i++) begin
            send_beats(1, 0, 64'h2000 + DW'(i));
            wait_b(8'h20 + ID_W'(i), (i == 3) ? 2'b10 : 2'b00);
            if (i != 3) exp_wr(16'h0400 + AW'(i * 16), 64'h2000 + DW'(i), 0);
        end
        check_writes("backpressure");

        // Reset during the second beat of a burst
        send_aw(8'h77, 16'h0500, 8'd3, 3'd3, 2'b01);
        send_beats(1, 99, 64'h7000);
        exp_wr(16'h0500, 64'h7000, 0);
        axi_wvalid = 1'b1; axi_wdata = 64'h7001; axi_wstrb = 8'hFE;
        rst_n = 1'b0;
        @(negedge clk);
        axi_wvalid = 1'b0;
        check("mid_rst_awready", OBS_W'(axi_awready), OBS_W'(0));
        check("mid_rst_wr_en", OBS_W'(wr_en), OBS_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rise_awready", OBS_W'(axi_awready), OBS_W'(1));
        check("rst_rise_wready", OBS_W'(axi_wready), OBS_W'(0));
        repeat (6) begin
            @(negedge clk);
            check("rst_no_b", OBS_W'(axi_bvalid), OBS_W'(0));
        end
        check_writes("reset_mid");

        // 4 KB boundary crossing
        send_aw(8'h88, 16'h0FF8, 8'd1, 3'd3, 2'b01);
        send_beats(2, 1, 64'h8000);
`ifdef AXI_WR_BOUNDARY_CHK_EN
        wait_b(8'h88, 2'b10);
`else
        wait_b(8'h88, 2'b00);
        exp_wr(16'h0FF8, 64'h8000, 0); exp_wr(16'h1000, 64'h8001, 1);
`endif
        check_writes("boundary");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
